// File: rtl/multitap_pkg.sv
// Shared keycodes, line-feed terminator and controller state type for multitap_msg_ctrl.
// MULTITAP_TX_TERMINATOR_EN adds the TERM state.
package multitap_pkg;
    localparam logic [7:0] KEY_MODE  = 8'h28;
    localparam logic [7:0] KEY_SHIFT = 8'h84;
    localparam logic [7:0] KEY_CLR   = 8'h48;
    localparam logic [7:0] KEY_SEND  = 8'h88;
    localparam logic [7:0] CHAR_LF   = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_SEND
`ifdef MULTITAP_TX_TERMINATOR_EN
        , ST_TERM
`endif
    } state_t;
endpackage

// File: rtl/multitap_timeout.sv
// Idle timer for the pending multi-tap character: counts enabled cycles and
// pulses o_expire on the TIMEOUT_CYC-th one, then restarts from zero.
module multitap_timeout #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr || o_expire)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/multitap_msg_ctrl.sv
// Multi-tap message sequencer: pending char, commit/backspace into a buffer, byte-wise send.
// Define MULTITAP_TX_TERMINATOR_EN to append a line feed after each sent message.
module multitap_msg_ctrl
    import multitap_pkg::*;
#(
    parameter int MSG_DEPTH   = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           strobe,
    input  logic [7:0]                     keycode,
    input  logic [7:0]                     char_in,
    input  logic                           tx_ready,
    output logic                           tx_valid,
    output logic [7:0]                     tx_data,
    output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
    output logic                           pending,
    output logic [7:0]                     pending_char,
    output logic                           busy,
    output logic                           overflow
);
    localparam int LEN_W = $clog2(MSG_DEPTH + 1);
    localparam int RD_W  = $clog2(MSG_DEPTH);

    state_t           r_state, w_nxt;
    logic [7:0]       r_buf [MSG_DEPTH];
    logic [LEN_W-1:0] r_msg_len;
    logic [RD_W-1:0]  r_rd_idx;
    logic [7:0]       r_pend_char, r_pend_key;
    logic             r_overflow;

    logic w_is_char, w_full, w_last, w_expire, w_tmo_en, w_tmo_clr;
    logic w_commit, w_load, w_dec, w_tx_acc, w_send_done;

    assign w_is_char = !(keycode inside {KEY_MODE, KEY_SHIFT, KEY_CLR, KEY_SEND});
    assign w_full    = (r_msg_len == LEN_W'(MSG_DEPTH));
    assign w_last    = (LEN_W'(r_rd_idx) == r_msg_len - LEN_W'(1));
    // A strobe always restarts the timer, so it beats a same-cycle expiry.
    assign w_tmo_en  = (r_state == ST_PEND) && !strobe;
    assign w_tmo_clr = strobe && (r_state == ST_IDLE || r_state == ST_PEND);

    multitap_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt       = r_state;
        w_commit    = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_tx_acc    = 1'b0;
        w_send_done = 1'b0;
        case (r_state)
            ST_IDLE: if (strobe) begin
                if (w_is_char) begin
                    w_load = 1'b1;
                    w_nxt  = ST_PEND;
                end else if (keycode == KEY_CLR) begin
                    w_dec = (r_msg_len != '0);
                end else if (keycode == KEY_SEND && r_msg_len != '0) begin
                    w_nxt = ST_SEND;
                end
            end
            ST_PEND: if (strobe) begin
                if (w_is_char) begin
                    w_commit = (keycode != r_pend_key);
                    w_load   = 1'b1;
                end else if (keycode == KEY_CLR) begin
                    w_nxt = ST_IDLE;
                end else begin
                    w_commit = 1'b1;
                    w_nxt    = (keycode == KEY_SEND) ? ST_SEND : ST_IDLE;
                end
            end else if (w_expire) begin
                w_commit = 1'b1;
                w_nxt    = ST_IDLE;
            end
            ST_SEND: if (tx_ready) begin
                w_tx_acc = 1'b1;
                if (w_last) begin
                    w_send_done = 1'b1;
`ifdef MULTITAP_TX_TERMINATOR_EN
                    w_nxt = ST_TERM;
`else
                    w_nxt = ST_IDLE;
`endif
                end
            end
`ifdef MULTITAP_TX_TERMINATOR_EN
            ST_TERM: if (tx_ready) w_nxt = ST_IDLE;
`endif
            default: w_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msg_len   <= '0;
            r_rd_idx    <= '0;
            r_pend_char <= '0;
            r_pend_key  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= w_commit && w_full;
            if (w_load) begin
                r_pend_char <= char_in;
                r_pend_key  <= keycode;
            end
            if (w_commit && !w_full) r_msg_len <= r_msg_len + 1'b1;
            if (w_dec)               r_msg_len <= r_msg_len - 1'b1;
            if (w_send_done) begin
                r_msg_len <= '0;
                r_rd_idx  <= '0;
            end else if (w_tx_acc) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
        end
    end

    // Buffer contents need no reset: nothing reads past msg_len.
    always_ff @(posedge clk) begin
        if (w_commit && !w_full) r_buf[RD_W'(r_msg_len)] <= r_pend_char;
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (r_state)
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = r_buf[r_rd_idx];
            end
`ifdef MULTITAP_TX_TERMINATOR_EN
            ST_TERM: begin
                tx_valid = 1'b1;
                tx_data  = CHAR_LF;
            end
`endif
            default: ;
        endcase
    end

    assign busy         = tx_valid;
    assign pending      = (r_state == ST_PEND);
    assign pending_char = r_pend_char;
    assign msg_len      = r_msg_len;
    assign overflow     = r_overflow;
endmodule

// File: doc/multitap_msg_ctrl.md
Name: multitap_msg_ctrl

Overview:
Sequencer between the keypad mode/shift/key-count logic and the message transmitter. Holds the current multi-tap candidate character as "pending", commits it to a message buffer when a different key is pressed or a timeout expires, and handles backspace. On a send request it drains the buffer byte-by-byte over a valid/ready handshake.

Parameters:
MSG_DEPTH, 16, message buffer capacity in characters (power of two not required, >=2)
TIMEOUT_CYC, 1000000, idle cycles after the last press of a key before the pending character auto-commits (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
strobe  input  1  one-cycle pulse per debounced key press
keycode  input  8  keycode of the press; valid when strobe=1
char_in  input  8  decoded ASCII for keycode/key_count/mode/upper; valid when strobe=1
tx_ready  input  1  transmitter accepts tx_data this cycle
tx_valid  output  1  tx_data valid
tx_data  output  8  outgoing character
msg_len  output  $clog2(MSG_DEPTH+1)  committed characters in buffer
pending  output  1  a candidate character is held
pending_char  output  8  current candidate (display)
busy  output  1  high in SEND (and TERM); presses ignored
overflow  output  1  one-cycle pulse when a commit is dropped because the buffer is full

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, msg_len=0, timer=0, rd_idx=0. Reset mid-SEND aborts the send and discards the buffer.
- Special keycodes: KEY_MODE=8'h28, KEY_SHIFT=8'h84, KEY_CLR=8'h48, KEY_SEND=8'h88. Every other keycode is a character key.
- States: IDLE, PEND, SEND, TERM (TERM only with the optional feature).
- IDLE + strobe with a character key -> pending_char<=char_in, pending_key<=keycode, timer<=0, go to PEND.
- IDLE + KEY_CLR -> if msg_len>0, msg_len decrements; otherwise no change.
- IDLE + KEY_MODE or KEY_SHIFT -> no change.
- IDLE + KEY_SEND -> go to SEND if msg_len>0; otherwise ignored.
- PEND + same character key -> pending_char<=char_in (next tap), timer<=0.
- PEND + different character key -> commit the old pending char; new pending takes char_in/keycode; timer<=0; stay in PEND.
- PEND + KEY_MODE or KEY_SHIFT -> commit, go to IDLE.
- PEND + KEY_CLR -> discard pending (no commit), go to IDLE.
- PEND + KEY_SEND -> commit, go to SEND.
- PEND with no strobe: timer increments; at timer==TIMEOUT_CYC-1 -> commit, go to IDLE.
- Strobe and timeout in the same cycle: the strobe wins and the timeout is cancelled.
- Commit: buf[msg_len]<=pending_char and msg_len++ (visible one cycle after the triggering strobe or timeout). If msg_len==MSG_DEPTH, the char is dropped and overflow pulses for one cycle.
- pending=1 exactly in PEND.
- SEND: tx_valid=1, tx_data=buf[rd_idx]. On tx_valid&&tx_ready, rd_idx++. tx_data stays stable while tx_valid&&!tx_ready.
- SEND completion: on acceptance of index msg_len-1, go to IDLE (or TERM), and msg_len<=0, rd_idx<=0 in the same cycle.
- Strobes in SEND/TERM are ignored entirely, not queued.
- Widths: timer is $clog2(TIMEOUT_CYC) bits; rd_idx is $clog2(MSG_DEPTH) bits; no wrap, because indices are bounded by msg_len.

Optional Feature:
MULTITAP_TX_TERMINATOR_EN
- Defined: after the last buffer byte is accepted, enter TERM and present tx_data=8'h0A with tx_valid=1 until tx_ready, then go to IDLE. busy stays high through TERM.
- Undefined: no TERM state; SEND goes directly to IDLE.

Decomposition:
- Package multitap_pkg: KEY_MODE, KEY_SHIFT, KEY_CLR, KEY_SEND localparams, CHAR_LF=8'h0A, state enum type.
- One sub-module, multitap_timeout: resettable counter with clear input, enable, and expire pulse output, parameterised by TIMEOUT_CYC.
- Buffer is a register array inside the top.

Test Plan:
- Use TIMEOUT_CYC=8. Press 8'h11 with char 'a', press 8'h11 with 'b', then idle 8 cycles -> msg_len=1, buf[0]='b', pending=0.
- Press 8'h11 'a', then 8'h12 'd' within timeout -> msg_len=1 ('a') on the next cycle, pending_char='d'; after timeout, msg_len=2.
- PEND + KEY_CLR -> pending discarded, msg_len unchanged. IDLE + KEY_CLR with msg_len=2 -> msg_len=1. KEY_CLR at msg_len=0 -> stays 0.
- Fill to MSG_DEPTH=4, commit a 5th char -> overflow pulses exactly 1 cycle, msg_len stays 4.
- Buffer "hi", press KEY_SEND, hold tx_ready=0 for 3 cycles then 1 -> tx_data 'h' stable, then 'i'; msg_len=0, busy=0. Strobes sent during SEND are ignored. With MULTITAP_TX_TERMINATOR_EN, 8'h0A follows 'i'.
- Assert rst mid-SEND after 1 byte -> all outputs 0 immediately (asynchronously), state IDLE.
